uart_rx_block: RTL
==================

Name: uart_rx_block

Overview:
Serial receive front end: detects a start bit on an asynchronous line and times mid-bit samples with internal bit-period/bit-count counters. It shifts in an LSB-first data word, checks the stop bit and presents the byte with a data_ready/data_read handshake. Sits between the pad-level serial input and the byte-consuming logic downstream.

Parameters:
CLKS_PER_BIT, 10, clk cycles per serial bit; legal range 4..255.
DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
serial_in  in  1  asynchronous serial line, idle high
data_read  in  1  consumer pulse: rx_data taken
rx_data  out  DATA_BITS  last good received word
data_ready  out  1  rx_data holds unread word
overrun_error  out  1  good word arrived while previous still unread
framing_error  out  1  last frame had stop bit == 0

Behaviour:
- Reset: n_rst is asynchronous, active-low; clock is clk.
- Reset values:
  - rx_data = all ones; data_ready = 0; overrun_error = 0; framing_error = 0.
  - Both synchroniser flops = 1; prev-sample flop = 1; FSM = IDLE; counters = 0.
  - Reset mid-frame aborts the frame; no outputs change except to their reset values.
- Input path: serial_in passes through a 2-flop synchroniser (sync), then one more flop (prev). start_edge = prev & ~sync.
- Bit-period counter tc:
  - Range 0..CLKS_PER_BIT-1, wraps to 0.
  - Set to 0 in the cycle start_edge is seen in IDLE; increments every cycle outside IDLE.
  - sample strobe = (tc == CLKS_PER_BIT/2), integer divide.
- Bit counter bc: range 0..DATA_BITS-1, cleared on entering DATA.
- FSM:
  - IDLE: on start_edge -> START.
  - START: on sample, if sync==1 (false start) -> IDLE with no output change; else -> DATA.
  - DATA: on sample, shift sync into MSB of shift register (LSB-first frame); bc++. On the sample where bc==DATA_BITS-1 -> STOP.
  - STOP: on sample, capture stop_bit = sync -> LOAD.
  - LOAD: one cycle, update outputs, -> IDLE.
  - A new start_edge is honoured from the first IDLE cycle.
- LOAD rules, registered, visible the cycle after LOAD:
  - stop_bit==1:
    - rx_data <= shift register; data_ready <= 1; framing_error <= 0.
    - overrun_error <= 1 if data_ready==1 and data_read==0 in the LOAD cycle; else unchanged.
  - stop_bit==0: framing_error <= 1; rx_data, data_ready and overrun_error unchanged.
- data_read:
  - Any cycle other than a good LOAD: data_ready <= 0 and overrun_error <= 0.
  - Coincident with a good LOAD: the load wins. data_ready stays 1, overrun_error not set.
- Latency (defaults, CLKS_PER_BIT = 10):
  - Stop sample occurs CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT = 95 cycles after the start_edge cycle.
  - data_ready rises 97 cycles after the start_edge cycle.
- Glitch shorter than CLKS_PER_BIT/2 cycles on an idle line: treated as a false start, no flags.
- serial_in held low continuously: every frame fails the stop check (framing_error = 1). No new frame starts until the line returns high, because an edge is required.

Decomposition:
- Shared package rx_pkg:
  - typedef enum rx_state_t {IDLE, START, DATA, STOP, LOAD}.
  - localparam defaults for CLKS_PER_BIT and DATA_BITS.
- One natural sub-module: start_bit_det, containing the synchroniser, prev flop and start_edge output.
- Counters, FSM and output registers stay in uart_rx_block.

Test Plan:
- Valid frame, defaults, data 0xA5 (LSB first), stop=1 -> data_ready rises exactly 97 cycles after start_edge; rx_data=0xA5; framing_error=0; overrun_error=0.
- Frame 0x3C with stop=0 -> framing_error=1; data_ready stays 0; rx_data keeps reset value 0xFF. A following good frame 0x11 -> framing_error=0, rx_data=0x11.
- Two good frames 0x55 then 0xAA with no data_read -> rx_data=0xAA, data_ready=1, overrun_error=1. Then a data_read pulse -> next cycle data_ready=0, overrun_error=0.
- data_read pulsed in the exact LOAD cycle of frame 0x0F, with 0xF0 unread -> rx_data=0x0F, data_ready=1, overrun_error=0.
- Line low for 3 cycles then high -> FSM returns to IDLE after the start sample; all outputs unchanged. A valid frame 0x81 sent immediately after is received correctly.
- n_rst asserted during data bit 4 of a frame -> all outputs at reset values immediately. A fresh frame 0x7E after release -> rx_data=0x7E, no errors.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and defaults for the UART receive slice.
package rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      LOAD
   } rx_state_t;

   localparam int unsigned CLKS_PER_BIT_DEF = 10;
   localparam int unsigned DATA_BITS_DEF    = 8;

   // Wide enough for the largest legal bit period (255 clocks).
   localparam int unsigned TC_W = 8;

endpackage

// File: rtl/start_bit_det.sv
// Brings the asynchronous serial line into the clk domain and flags the
// falling edge that may mark a start bit.
module start_bit_det (
   input  logic clk,
   input  logic n_rst,
   input  logic serial_in,
   output logic sync,
   output logic start_edge
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   // NOTE: always_comb uses blocking '=' for next-state logic; flops use non-blocking '<=' only.
   always_comb begin
      meta_d = serial_in;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // The line idles high, so all three stages reset high to avoid a phantom edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync       = sync_q;
   assign start_edge = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_block.sv
// UART receive front end: mid-bit sampling of an LSB-first frame, stop-bit
// check and a data_ready/data_read handshake toward the byte consumer.
module uart_rx_block
   import rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 serial_in,
   input  logic                 data_read,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 data_ready,
   output logic                 overrun_error,
   output logic                 framing_error
);

   localparam int unsigned   BC_W    = $clog2(DATA_BITS);
   localparam logic [TC_W-1:0] TC_MAX  = TC_W'(CLKS_PER_BIT - 1);
   localparam logic [TC_W-1:0] TC_MID  = TC_W'(CLKS_PER_BIT / 2);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

   logic sync;
   logic start_edge;

   start_bit_det u_start_bit_det (
      .clk        (clk),
      .n_rst      (n_rst),
      .serial_in  (serial_in),
      .sync       (sync),
      .start_edge (start_edge)
   );

   rx_state_t            state_q, state_d;
   logic [TC_W-1:0]      tc_q, tc_d;
   logic [BC_W-1:0]      bc_q, bc_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 stop_bit_q, stop_bit_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 data_ready_q, data_ready_d;
   logic                 overrun_q, overrun_d;
   logic                 framing_q, framing_d;
   logic                 sample;
   logic                 good_load;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d      = state_q;
      bc_d         = bc_q;
      shift_d      = shift_q;
      stop_bit_d   = stop_bit_q;
      rx_data_d    = rx_data_q;
      data_ready_d = data_ready_q;
      overrun_d    = overrun_q;
      framing_d    = framing_q;
      sample       = (tc_q == TC_MID);
      good_load    = (state_q == LOAD) && stop_bit_q;

      case (state_q)
         IDLE: begin
            if (start_edge) state_d = START;
         end
         START: begin
            if (sample) begin
               if (sync) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  bc_d    = '0;
               end
            end
         end
         DATA: begin
            if (sample) begin
               shift_d = {sync, shift_q[DATA_BITS-1:1]};
               bc_d    = bc_q + BC_W'(1);
               if (bc_q == BC_LAST) state_d = STOP;
            end
         end
         STOP: begin
            if (sample) begin
               stop_bit_d = sync;
               state_d    = LOAD;
            end
         end
         LOAD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // tc sits at 0 in IDLE, so the start-edge cycle counts as phase 0 of the start bit.
      if (state_d == IDLE)     tc_d = '0;
      else if (tc_q == TC_MAX) tc_d = '0;
      else                     tc_d = tc_q + TC_W'(1);

      // A good load takes priority over a coincident data_read.
      if (good_load) begin
         rx_data_d    = shift_q;
         data_ready_d = 1'b1;
         framing_d    = 1'b0;
         if (data_ready_q && !data_read) overrun_d = 1'b1;
      end else begin
         if (state_q == LOAD) framing_d = 1'b1;
         if (data_read) begin
            data_ready_d = 1'b0;
            overrun_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         tc_q         <= '0;
         bc_q         <= '0;
         // NOTE: the shift register is reset too; it is small and a known value keeps rx_data deterministic.
         shift_q      <= '1;
         stop_bit_q   <= 1'b0;
         rx_data_q    <= '1;
         data_ready_q <= 1'b0;
         overrun_q    <= 1'b0;
         framing_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         tc_q         <= tc_d;
         bc_q         <= bc_d;
         shift_q      <= shift_d;
         stop_bit_q   <= stop_bit_d;
         rx_data_q    <= rx_data_d;
         data_ready_q <= data_ready_d;
         overrun_q    <= overrun_d;
         framing_q    <= framing_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign data_ready    = data_ready_q;
   assign overrun_error = overrun_q;
   assign framing_error = framing_q;

endmodule
